dp_mem_sync: RTL

//  Parametrised dual-port byte-addressable memory for simulation and FPGA.

---
 rtl/dp_mem_sync.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dp_mem_sync.sv
// Dual-port byte-addressable memory: read-only fetch port A, byte-enabled data port B.
// Both ports answer every accepted request after a fixed registered latency.
`timescale 1ns / 1ps

module dp_mem_sync #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned IWIDTH      = 32,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [63:0]       if_addr_i,
    output logic              if_valid_o,
    output logic [IWIDTH-1:0] if_data_o,
    output logic              if_err_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [7:0]        mem_be_i,
    input  logic [63:0]       mem_addr_i,
    input  logic [63:0]       mem_wdata_i,
    output logic              mem_rvalid_o,
    output logic [63:0]       mem_rdata_o,
    output logic              mem_err_o
);

    localparam int unsigned AW     = $clog2(DEPTH_BYTES);
    localparam int unsigned IBYTES = IWIDTH / 8;

    logic [7:0] mem [DEPTH_BYTES];

    initial begin
        for (int unsigned i = 0; i < DEPTH_BYTES; i++) mem[i] = 8'h00;
    end

    // 65-bit end offset so addresses near 2^64 cannot wrap back into range.
    function automatic logic out_of_range(input logic [63:0] addr, input logic [3:0] nbytes);
        logic [64:0] end_off;
        end_off = {1'b0, addr - BASE_ADDR} + 65'(nbytes);
        return (addr < BASE_ADDR) || (end_off > 65'(DEPTH_BYTES));
    endfunction

    logic [AW-1:0]     if_off, mem_off;
    logic              if_err_c, mem_err_c;
    logic [IWIDTH-1:0] if_data_c;
    logic [63:0]       mem_rdata_c;
    logic [3:0]        mem_bytes;

    assign if_off  = AW'(if_addr_i - BASE_ADDR);
    assign mem_off = AW'(mem_addr_i - BASE_ADDR);

    always_comb begin
        if_err_c  = out_of_range(if_addr_i, 4'(IBYTES));
        if_data_c = '0;
        if (!if_err_c) begin
            for (int unsigned k = 0; k < IBYTES; k++) begin
                if_data_c[8*k +: 8] = mem[if_off + AW'(k)];
            end
        end
    end

    always_comb begin
        mem_bytes = 4'd0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (mem_be_i[k]) mem_bytes = 4'(k + 1);
        end
        mem_err_c   = out_of_range(mem_addr_i, mem_bytes);
        mem_rdata_c = '0;
        if (!mem_err_c && !mem_we_i) begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (mem_be_i[k]) mem_rdata_c[8*k +: 8] = mem[mem_off + AW'(k)];
            end
        end
    end

    // Non-blocking write: a same-edge read on either port sees the old byte.
    always_ff @(posedge clk) begin
        if (!rst && mem_req_i && mem_we_i && !mem_err_c) begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (mem_be_i[k]) mem[mem_off + AW'(k)] <= mem_wdata_i[8*k +: 8];
            end
        end
    end

    logic [LATENCY-1:0] if_vld_q, if_err_q, mem_vld_q, mem_err_q;
    logic [IWIDTH-1:0]  if_dat_q  [LATENCY];
    logic [63:0]        mem_dat_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            if_vld_q  <= '0;
            if_err_q  <= '0;
            mem_vld_q <= '0;
            mem_err_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                if_dat_q[i]  <= '0;
                mem_dat_q[i] <= '0;
            end
        end else begin
            if_vld_q[0]  <= if_req_i;
            if_err_q[0]  <= if_req_i & if_err_c;
            if_dat_q[0]  <= if_req_i ? if_data_c : '0;
            mem_vld_q[0] <= mem_req_i;
            mem_err_q[0] <= mem_req_i & mem_err_c;
            mem_dat_q[0] <= mem_req_i ? mem_rdata_c : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                if_vld_q[i]  <= if_vld_q[i-1];
                if_err_q[i]  <= if_err_q[i-1];
                if_dat_q[i]  <= if_dat_q[i-1];
                mem_vld_q[i] <= mem_vld_q[i-1];
                mem_err_q[i] <= mem_err_q[i-1];
                mem_dat_q[i] <= mem_dat_q[i-1];
            end
        end
    end

    assign if_valid_o   = if_vld_q[LATENCY-1];
    assign if_err_o     = if_err_q[LATENCY-1];
    assign if_data_o    = if_dat_q[LATENCY-1];
    assign mem_rvalid_o = mem_vld_q[LATENCY-1];
    assign mem_err_o    = mem_err_q[LATENCY-1];
    assign mem_rdata_o  = mem_dat_q[LATENCY-1];

endmodule
